// File: rtl/ula_issue_if.sv
// ula_issue_if -- bundle of signals between decode, the ALU issue stage and EX.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until the transfer.
// in_ready does not depend on in_valid. out_valid does not depend on out_ready.
//
// Signals:
//   in_valid, in_ready          upstream handshake
//   alu_op, funct, alu_src      decode controls
//   rs_data, rt_data, imm16     operand sources
//   rd_in                       destination tag
//   flush                       synchronous kill of all held entries
//   out_valid, out_ready        downstream handshake
//   inputULA, a, b, rd_out      head entry presented to the ALU
//   illegal                     head entry has an undecodable operation
//
// Modports:
//   master  environment side (drives decode inputs and out_ready)
//   slave   the issue stage
interface ula_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm16;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  inputULA;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_out;
    logic        illegal;

    modport master (
        output in_valid, alu_op, funct, alu_src, rs_data, rt_data, imm16,
               rd_in, flush, out_ready,
        input  in_ready, out_valid, inputULA, a, b, rd_out, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct, alu_src, rs_data, rt_data, imm16,
               rd_in, flush, out_ready,
        output in_ready, out_valid, inputULA, a, b, rd_out, illegal
    );
endinterface

// File: rtl/ula_issue.sv
// ula_issue -- ALU issue stage: decodes ALU control at accept and holds up to
// two instructions in a skid buffer (head + skid) in front of the ALU.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        ula_issue_if.slave (handshakes, decode inputs, head outputs)
//   dbg_state  current buffer state (0 EMPTY, 1 ONE, 2 FULL)
//
// All outputs come straight from flops: the head entry register, and
// in_ready/out_valid flops loaded from the next state.
module ula_issue (
    input  logic        clk,
    input  logic        rst_n,
    ula_issue_if.slave  bus,
    output logic [1:0]  dbg_state
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    typedef struct packed {
        logic [3:0]  code;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } entry_t;

    localparam entry_t ENTRY_RST = '{code: 4'b1111, ill: 1'b0, a: 32'd0,
                                     b: 32'd0, rd: 5'd0};

    logic [1:0] state, next_state;
    logic       in_ready_q, out_valid_q;
    entry_t     head_q, skid_q, new_entry;
    logic       accept, consume;
    logic       load_head, head_from_skid, load_skid;

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = out_valid_q & bus.out_ready;

    // Decode of the offered instruction; stored with the entry at accept.
    always_comb begin
        new_entry.code = 4'b1111;
        new_entry.ill  = 1'b1;
        new_entry.a    = bus.rs_data;
        new_entry.b    = bus.alu_src ? {{16{bus.imm16[15]}}, bus.imm16} : bus.rt_data;
        new_entry.rd   = bus.rd_in;
        case (bus.alu_op)
            2'b00: begin new_entry.code = 4'b0010; new_entry.ill = 1'b0; end
            2'b01: begin new_entry.code = 4'b0110; new_entry.ill = 1'b0; end
            2'b10: begin
                new_entry.ill = 1'b0;
                case (bus.funct)
                    6'b100000: new_entry.code = 4'b0010;
                    6'b100010: new_entry.code = 4'b0110;
                    6'b100100: new_entry.code = 4'b0000;
                    6'b100101: new_entry.code = 4'b0001;
                    6'b101010: new_entry.code = 4'b0111;
                    default: begin
                        new_entry.code = 4'b1111;
                        new_entry.ill  = 1'b1;
                    end
                endcase
            end
            default: begin new_entry.code = 4'b1111; new_entry.ill = 1'b1; end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= next_state;
    end

    // Next-state logic; flush wins over any accept/consume in the same cycle.
    always_comb begin
        next_state = state;
        if (bus.flush) begin
            next_state = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (accept) next_state = S_ONE;
                S_ONE: begin
                    if (accept && !consume)      next_state = S_FULL;
                    else if (consume && !accept) next_state = S_EMPTY;
                end
                S_FULL:  if (consume) next_state = S_ONE;
                default: next_state = S_EMPTY;
            endcase
        end
    end

    // Output/control logic: which entry registers load this cycle.
    always_comb begin
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (!bus.flush) begin
            case (state)
                S_EMPTY: load_head = accept;
                S_ONE: begin
                    if (accept && consume) load_head = 1'b1;
                    else if (accept)       load_skid = 1'b1;
                end
                S_FULL: begin
                    if (consume) begin
                        load_head      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= ENTRY_RST;
            skid_q      <= ENTRY_RST;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (load_head) head_q <= head_from_skid ? skid_q : new_entry;
            if (load_skid) skid_q <= new_entry;
            in_ready_q  <= (next_state != S_FULL);
            out_valid_q <= (next_state != S_EMPTY);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.inputULA  = head_q.code;
    assign bus.illegal   = head_q.ill;
    assign bus.a         = head_q.a;
    assign bus.b         = head_q.b;
    assign bus.rd_out    = head_q.rd;
    assign dbg_state     = state;
endmodule

// File: tb/tb_ula_issue.sv
// tb_ula_issue -- directed bench for ula_issue: decode table plus hand-written
// sequences for back-pressure, streaming, flush and asynchronous reset.
// Inputs change 1 time unit after a rising edge; consumes are observed on
// the falling edge and checked against an expected queue of {rd, a}.
module tb_ula_issue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    logic [36:0] exp_q[$];

    ula_issue_if bus();

    ula_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            logic [36:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver: unexpected entry rd=%0d a=%h", bus.rd_out, bus.a);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rd_out, bus.a} !== e) begin
                    errors++;
                    $display("FAIL deliver: got rd=%0d a=%h expected rd=%0d a=%h",
                             bus.rd_out, bus.a, e[36:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] tag);
        bus.in_valid = 1'b1;
        bus.alu_op   = 2'b00;
        bus.funct    = 6'd0;
        bus.alu_src  = 1'b0;
        bus.rs_data  = tag;
        bus.rt_data  = ~tag;
        bus.imm16    = 16'd0;
        bus.rd_in    = tag[4:0];
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, " in_ready"},  {31'd0, bus.in_ready},  32'd1);
        chk({tag, " inputULA"},  {28'd0, bus.inputULA},  32'hF);
        chk({tag, " a"},         bus.a,                  32'd0);
        chk({tag, " b"},         bus.b,                  32'd0);
        chk({tag, " rd_out"},    {27'd0, bus.rd_out},    32'd0);
        chk({tag, " illegal"},   {31'd0, bus.illegal},   32'd0);
        chk({tag, " state"},     {30'd0, dbg_state},     32'd0);
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic        src;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [3:0]  code;
        logic        ill;
        logic [31:0] b;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [5:0] fn,
                                input logic src, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [15:0] imm,
                                input logic [4:0] rd, input logic [3:0] code,
                                input logic ill, input logic [31:0] b);
        vec_t v;
        v.op = op; v.fn = fn; v.src = src; v.rs = rs; v.rt = rt;
        v.imm = imm; v.rd = rd; v.code = code; v.ill = ill; v.b = b;
        return v;
    endfunction

    vec_t vt[11];

    initial begin
        vt[0]  = mk(2'b10, 6'b100000, 1'b0, 32'd5,  32'd7,  16'h0000, 5'd1,  4'b0010, 1'b0, 32'd7);
        vt[1]  = mk(2'b00, 6'b000000, 1'b1, 32'd9,  32'd3,  16'hFFFE, 5'd2,  4'b0010, 1'b0, 32'hFFFFFFFE);
        vt[2]  = mk(2'b00, 6'b111111, 1'b1, 32'd10, 32'd3,  16'h7FFF, 5'd3,  4'b0010, 1'b0, 32'h00007FFF);
        vt[3]  = mk(2'b01, 6'b000000, 1'b0, 32'd11, 32'd12, 16'h1234, 5'd4,  4'b0110, 1'b0, 32'd12);
        vt[4]  = mk(2'b10, 6'b100010, 1'b0, 32'd13, 32'd14, 16'h0000, 5'd5,  4'b0110, 1'b0, 32'd14);
        vt[5]  = mk(2'b10, 6'b100100, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0000, 5'd6, 4'b0000, 1'b0, 32'h0FF00FF0);
        vt[6]  = mk(2'b10, 6'b100101, 1'b0, 32'd15, 32'd16, 16'h0000, 5'd7,  4'b0001, 1'b0, 32'd16);
        vt[7]  = mk(2'b10, 6'b101010, 1'b0, 32'd17, 32'd18, 16'h0000, 5'd8,  4'b0111, 1'b0, 32'd18);
        vt[8]  = mk(2'b10, 6'b000000, 1'b0, 32'd19, 32'd20, 16'h0000, 5'd9,  4'b1111, 1'b1, 32'd20);
        vt[9]  = mk(2'b11, 6'b100000, 1'b0, 32'd21, 32'd22, 16'h0000, 5'd10, 4'b1111, 1'b1, 32'd22);
        vt[10] = mk(2'b10, 6'b100000, 1'b1, 32'd23, 32'd24, 16'h8000, 5'd31, 4'b0010, 1'b0, 32'hFFFF8000);
    end

    // ---------------- test sequence ----------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.alu_op    = 2'b00;
        bus.funct     = 6'd0;
        bus.alu_src   = 1'b0;
        bus.rs_data   = 32'd0;
        bus.rt_data   = 32'd0;
        bus.imm16     = 16'd0;
        bus.rd_in     = 5'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held for a few cycles.
        step(); step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Decode table: accept from EMPTY, check head next cycle, then consume.
        for (int i = 0; i < 11; i++) begin
            bus.in_valid  = 1'b1;
            bus.alu_op    = vt[i].op;
            bus.funct     = vt[i].fn;
            bus.alu_src   = vt[i].src;
            bus.rs_data   = vt[i].rs;
            bus.rt_data   = vt[i].rt;
            bus.imm16     = vt[i].imm;
            bus.rd_in     = vt[i].rd;
            bus.out_ready = 1'b0;
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("vec%0d inputULA", i),  {28'd0, bus.inputULA},  {28'd0, vt[i].code});
            chk($sformatf("vec%0d illegal", i),   {31'd0, bus.illegal},   {31'd0, vt[i].ill});
            chk($sformatf("vec%0d a", i),         bus.a,                  vt[i].rs);
            chk($sformatf("vec%0d b", i),         bus.b,                  vt[i].b);
            exp_q.push_back({vt[i].rd, vt[i].rs});
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            chk($sformatf("vec%0d drained", i), {31'd0, bus.out_valid}, 32'd0);
        end

        // Back-pressure: I1, I2 held, I3 refused until space frees up.
        bus.out_ready = 1'b0;
        offer(32'h101); exp_q.push_back({5'h01, 32'h101});
        step();
        chk("bp one in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("bp one head", bus.a, 32'h101);
        offer(32'h102); exp_q.push_back({5'h02, 32'h102});
        step();
        chk("bp full in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp full state", {30'd0, dbg_state}, 32'd2);
        offer(32'h103);
        step();
        chk("bp hold in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp hold head a", bus.a, 32'h101);
        chk("bp hold head b", bus.b, ~32'h101);
        bus.out_ready = 1'b1;
        step();
        chk("bp skid head", bus.a, 32'h102);
        chk("bp skid in_ready", {31'd0, bus.in_ready}, 32'd1);
        exp_q.push_back({5'h03, 32'h103});
        step();
        chk("bp I3 head", bus.a, 32'h103);
        chk("bp I3 state", {30'd0, dbg_state}, 32'd1);
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        chk("bp empty", {31'd0, bus.out_valid}, 32'd0);
        chk("bp queue drained", exp_q.size(), 32'd0);

        // Streaming: simultaneous accept and consume for 8 cycles in ONE.
        offer(32'h200); exp_q.push_back({5'h00, 32'h200});
        step();
        for (int k = 1; k <= 8; k++) begin
            offer(32'h200 + k); exp_q.push_back({5'(k), 32'h200 + k});
            bus.out_ready = 1'b1;
            step();
            chk($sformatf("stream%0d in_ready", k), {31'd0, bus.in_ready}, 32'd1);
            chk($sformatf("stream%0d head", k), bus.a, 32'h200 + k);
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        chk("stream queue drained", exp_q.size(), 32'd0);
        chk("stream empty", {31'd0, bus.out_valid}, 32'd0);

        // Flush while FULL, with an offer and a consume in the same cycle.
        offer(32'h301);
        step();
        offer(32'h302);
        step();
        chk("flush pre state", {30'd0, dbg_state}, 32'd2);
        offer(32'h303);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("flush stays empty", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset mid-stream while FULL.
        offer(32'h401);
        step();
        offer(32'h402);
        bus.alu_op = 2'b11;
        step();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        #3;
        rst_n = 1'b1;
        step();
        chk("post reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("final queue empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ula_issue.md
ULA_ISSUE -- requirements
Module: ula_issue

Parameters
REQ-001 SHALL have no parameters; all widths fixed (32-bit data, 4-bit ALU control, 5-bit destination register).

Interface
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  upstream decode offers an instruction this cycle.
REQ-005 in_ready  out  1  stage can accept; registered output, depends on occupancy only.
REQ-006 alu_op  in  2  main-control class: 00 add, 01 sub, 10 R-type (use funct), 11 reserved.
REQ-007 funct  in  6  R-type function field.
REQ-008 alu_src  in  1  1 selects sign-extended imm16 as operand b; 0 selects rt_data.
REQ-009 rs_data, rt_data  in  32 each  register-file operands.
REQ-010 imm16  in  16  I-type immediate.
REQ-011 rd_in  in  5  destination register tag, carried unchanged.
REQ-012 flush  in  1  synchronous kill of all held entries (branch/exception).
REQ-013 out_valid  out  1  head entry presented to the ALU.
REQ-014 out_ready  in  1  ALU/EX stage consumes head this cycle.
REQ-015 inputULA  out  4  ALU control code of head entry.
REQ-016 a, b  out  32 each  ALU operands of head entry.
REQ-017 rd_out  out  5  destination tag of head entry.
REQ-018 illegal  out  1  head entry has an undecodable operation.

Function
REQ-019 SHALL be a 2-entry skid buffer with states EMPTY, ONE, FULL; occupancy = 0/1/2.
REQ-020 Accept = in_valid & in_ready; consume = out_valid & out_ready; both may occur in the same cycle.
REQ-021 Transitions: EMPTY+accept->ONE; ONE+accept&!consume->FULL; ONE+consume&!accept->EMPTY; ONE+both->ONE (new entry becomes head); FULL+consume->ONE (skid entry becomes head); otherwise hold.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; no accept in FULL regardless of out_ready.
REQ-023 out_valid SHALL be 1 exactly in ONE and FULL; head outputs stable while out_valid & !out_ready.
REQ-024 Latency: accepted instruction visible at outputs the cycle after accept when buffer was EMPTY.
REQ-025 Decode at accept, stored as 4-bit code: alu_op 00->0010, 01->0110, 11->1111 with illegal=1.
REQ-026 alu_op 10 funct map: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111; any other funct ->1111, illegal=1.
REQ-027 a SHALL equal rs_data at accept; b SHALL equal alu_src ? {16 copies of imm16[15], imm16} : rt_data.
REQ-028 Entries order-preserving; never dropped, duplicated or reordered except by flush.
REQ-029 flush=1 SHALL force EMPTY next cycle, overriding accept and consume in that cycle; in_ready=1 next cycle.
REQ-030 Illegal entries flow through normally (the ALU yields 0 for code 1111); the stage does not stall on them.
REQ-031 Operands not stored-through combinationally: out_* driven only from registers.

Reset
REQ-032 rst_n=0 SHALL immediately force state EMPTY, out_valid=0, in_ready=1, inputULA=4'b1111, a=b=0, rd_out=0, illegal=0.
REQ-033 Release of rst_n SHALL take effect on next rising clk; reset mid-transfer discards all held entries.

Verification
REQ-034 After reset: in_valid=1, alu_op=10, funct=100000, rs=5, rt=7, alu_src=0 -> next cycle out_valid=1, inputULA=0010, a=5, b=7.
REQ-035 alu_src=1, imm16=16'hFFFE, alu_op=00 -> b=32'hFFFFFFFE, inputULA=0010; imm16=16'h7FFF -> b=32'h00007FFF.
REQ-036 out_ready=0, three back-to-back offers I1,I2,I3 -> I1,I2 held, in_ready=0 after second accept, I3 not taken; out_ready=1 -> I1 then I2 delivered in order, then I3 accepted.
REQ-037 ONE state, simultaneous accept and consume each cycle for 8 cycles -> 8 instructions delivered in order, in_ready stays 1, one per cycle.
REQ-038 FULL state, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, nothing delivered.
REQ-039 alu_op=10, funct=000000 and alu_op=11 -> inputULA=1111, illegal=1; rst_n pulsed low mid-stream -> outputs at reset values without waiting for clk.
